// File: rtl/valid_mask_writer.sv
// Producer side of the ping-pong valid-mask RAM: packs one nonzero bit per activation into masks
// and writes them to successive banks. Optional macro VALID_MASK_POPCOUNT_EN adds the wr_nnz output.
module valid_mask_writer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned ACT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  in_valid,
    input  logic [ACT_WIDTH-1:0]  in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  rd_release,
    output logic                  wr_req,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  full,
    output logic                  empty,
    output logic                  underflow_err
`ifdef VALID_MASK_POPCOUNT_EN
    ,
    output logic [$clog2(DATA_WIDTH):0] wr_nnz
`endif
);

    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam int unsigned OCC_W     = ADDR_WIDTH + 1;
    localparam int unsigned LANE_W    = $clog2(DATA_WIDTH);
    localparam int unsigned NNZ_W     = $clog2(DATA_WIDTH) + 1;
    localparam logic [OCC_W-1:0]  FULL_OCC  = OCC_W'(DEPTH);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(DATA_WIDTH - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        WRITE   = 1'b1
    } state_e;

    state_e                  state_q;
    logic [LANE_W-1:0]       lane_q;
    logic [DATA_WIDTH-1:0]   mask_q;
    logic [DATA_WIDTH-1:0]   mask_d;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic [ADDR_WIDTH-1:0]   wptr_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [OCC_W-1:0]        occ_q;
    logic [OCC_W-1:0]        occ_d;
    logic                    underflow_q;

    logic ready_c;
    logic accept_c;
    logic act_nz_c;
    logic mask_done_c;
    logic write_fire_c;
    logic rel_ok_c;
    logic rel_under_c;

`ifdef VALID_MASK_POPCOUNT_EN
    logic [NNZ_W-1:0] nnz_q;
    logic [NNZ_W-1:0] wr_nnz_q;
`endif

    // Handshake, mask merge and occupancy next-state
    always_comb begin
        ready_c      = rst_n && clk_en && (state_q == COLLECT) && (occ_q < FULL_OCC);
        accept_c     = ready_c && in_valid;
        act_nz_c     = |in_data;
        mask_d       = mask_q;
        mask_d[lane_q] = act_nz_c;
        mask_done_c  = accept_c && ((lane_q == LAST_LANE) || in_last);
        write_fire_c = clk_en && (state_q == WRITE);
        rel_ok_c     = clk_en && rd_release && (occ_q != '0);
        rel_under_c  = clk_en && rd_release && (occ_q == '0);
        occ_d        = occ_q;
        if (write_fire_c && !rel_ok_c) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!write_fire_c && rel_ok_c) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // FSM and datapath registers; WRITE only retires while enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            lane_q      <= '0;
            mask_q      <= '0;
            wr_data_q   <= '0;
            wptr_q      <= '0;
            wr_addr_q   <= '0;
            occ_q       <= '0;
            underflow_q <= 1'b0;
`ifdef VALID_MASK_POPCOUNT_EN
            nnz_q       <= '0;
            wr_nnz_q    <= '0;
`endif
        end else begin
            occ_q <= occ_d;
            if (rel_under_c) begin
                underflow_q <= 1'b1;
            end
            case (state_q)
                COLLECT: begin
                    if (accept_c) begin
                        mask_q <= mask_d;
                        lane_q <= lane_q + LANE_W'(1);
`ifdef VALID_MASK_POPCOUNT_EN
                        nnz_q  <= nnz_q + NNZ_W'(act_nz_c);
`endif
                        if (mask_done_c) begin
                            state_q   <= WRITE;
                            wr_data_q <= mask_d;
                            wr_addr_q <= wptr_q;
`ifdef VALID_MASK_POPCOUNT_EN
                            wr_nnz_q  <= nnz_q + NNZ_W'(act_nz_c);
`endif
                        end
                    end
                end
                WRITE: begin
                    if (clk_en) begin
                        state_q <= COLLECT;
                        wptr_q  <= wptr_q + ADDR_WIDTH'(1);
                        lane_q  <= '0;
                        mask_q  <= '0;
`ifdef VALID_MASK_POPCOUNT_EN
                        nnz_q   <= '0;
`endif
                    end
                end
            endcase
        end
    end

    assign in_ready      = ready_c;
    assign wr_req        = rst_n && write_fire_c;
    assign wr_data       = wr_data_q;
    assign wr_addr       = wr_addr_q;
    assign occupancy     = occ_q;
    assign full          = (occ_q == FULL_OCC);
    assign empty         = (occ_q == '0);
    assign underflow_err = underflow_q;
`ifdef VALID_MASK_POPCOUNT_EN
    assign wr_nnz        = wr_nnz_q;
`endif

endmodule

// File: tb/tb_valid_mask_writer.sv
// Directed table-driven bench for valid_mask_writer (DATA_WIDTH=16, ADDR_WIDTH=1, ACT_WIDTH=8).
module tb_valid_mask_writer;

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 1;
    localparam int unsigned ACTW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clk_en;
    logic            in_valid;
    logic [ACTW-1:0] in_data;
    logic            in_last;
    logic            in_ready;
    logic            rd_release;
    logic            wr_req;
    logic [DW-1:0]   wr_data;
    logic [AW-1:0]   wr_addr;
    logic [AW:0]     occupancy;
    logic            full;
    logic            empty;
    logic            underflow_err;
`ifdef VALID_MASK_POPCOUNT_EN
    logic [4:0]      wr_nnz;
`endif

    always #5 clk = ~clk;

    valid_mask_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACT_WIDTH(ACTW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_en       (clk_en),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .rd_release   (rd_release),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .wr_addr      (wr_addr),
        .occupancy    (occupancy),
        .full         (full),
        .empty        (empty),
        .underflow_err(underflow_err)
`ifdef VALID_MASK_POPCOUNT_EN
        ,
        .wr_nnz       (wr_nnz)
`endif
    );

    typedef struct {
        logic            en;
        logic            v;
        logic [ACTW-1:0] d;
        logic            last;
        logic            rel;
        logic            ready;
        logic            req;
        logic [AW:0]     occ;
        logic            under;
        logic            chk_data;
        logic [DW-1:0]   data;
        logic [AW-1:0]   addr;
        logic [4:0]      nnz;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic en, input logic v, input logic [ACTW-1:0] d,
                                input logic last, input logic rel, input logic ready,
                                input logic req, input logic [AW:0] occ, input logic under,
                                input logic chk_data, input logic [DW-1:0] data,
                                input logic [AW-1:0] addr, input logic [4:0] nnz);
        vec_t t;
        t.en = en; t.v = v; t.d = d; t.last = last; t.rel = rel;
        t.ready = ready; t.req = req; t.occ = occ; t.under = under;
        t.chk_data = chk_data; t.data = data; t.addr = addr; t.nnz = nnz;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, compare the outputs of that cycle shortly after
    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        clk_en     = t.en;
        in_valid   = t.v;
        in_data    = t.d;
        in_last    = t.last;
        rd_release = t.rel;
        #1;
        chk({tag, " in_ready"},  32'(in_ready),      32'(t.ready));
        chk({tag, " wr_req"},    32'(wr_req),        32'(t.req));
        chk({tag, " occupancy"}, 32'(occupancy),     32'(t.occ));
        chk({tag, " full"},      32'(full),          32'(t.occ == 2'd2));
        chk({tag, " empty"},     32'(empty),         32'(t.occ == 2'd0));
        chk({tag, " underflow"}, 32'(underflow_err), 32'(t.under));
        if (t.chk_data) begin
            chk({tag, " wr_data"}, 32'(wr_data), 32'(t.data));
            chk({tag, " wr_addr"}, 32'(wr_addr), 32'(t.addr));
`ifdef VALID_MASK_POPCOUNT_EN
            chk({tag, " wr_nnz"},  32'(wr_nnz),  32'(t.nnz));
`endif
        end
    endtask

    // Reset for exactly one active edge, then check the post-reset state
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; clk_en = 1'b1; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; rd_release = 1'b0;
        #1;
        chk({tag, " in_ready in reset"}, 32'(in_ready), 32'd0);
        chk({tag, " wr_req in reset"},   32'(wr_req),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, " rst wr_req"},    32'(wr_req),        32'd0);
        chk({tag, " rst wr_data"},   32'(wr_data),       32'd0);
        chk({tag, " rst wr_addr"},   32'(wr_addr),       32'd0);
        chk({tag, " rst occupancy"}, 32'(occupancy),     32'd0);
        chk({tag, " rst full"},      32'(full),          32'd0);
        chk({tag, " rst empty"},     32'(empty),         32'd1);
        chk({tag, " rst underflow"}, 32'(underflow_err), 32'd0);
        chk({tag, " rst in_ready"},  32'(in_ready),      32'd1);
`ifdef VALID_MASK_POPCOUNT_EN
        chk({tag, " rst wr_nnz"},    32'(wr_nnz),        32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; rd_release = 1'b0;

        // Mask A: alternating 0/5 -> 16'hAAAA at bank 0
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1, 1, (i % 2 == 1) ? 8'd5 : 8'd0, 0, 0, 1, 0, 2'd0, 0, 0, 16'h0, 1'b0, 5'd0));
        tbl.push_back(mk(1, 0, 8'd0, 0, 0, 0, 1, 2'd0, 0, 1, 16'hAAAA, 1'b0, 5'd8));
        // Mask B: all nonzero -> 16'hFFFF at bank 1, then full
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1, 1, 8'(i + 1), 0, 0, 1, 0, 2'd1, 0, 0, 16'h0, 1'b0, 5'd0));
        tbl.push_back(mk(1, 0, 8'd0, 0, 0, 0, 1, 2'd1, 0, 1, 16'hFFFF, 1'b1, 5'd16));
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(1, 1, 8'd3, 0, 0, 0, 0, 2'd2, 0, 0, 16'h0, 1'b0, 5'd0));
        tbl.push_back(mk(1, 1, 8'd3, 0, 1, 0, 0, 2'd2, 0, 0, 16'h0, 1'b0, 5'd0));
        // Mask C: 3 nonzero with in_last -> 16'h0007 at wrapped bank 0; release during WRITE
        tbl.push_back(mk(1, 1, 8'd9, 0, 0, 1, 0, 2'd1, 0, 0, 16'h0, 1'b0, 5'd0));
        tbl.push_back(mk(1, 1, 8'd9, 0, 0, 1, 0, 2'd1, 0, 0, 16'h0, 1'b0, 5'd0));
        tbl.push_back(mk(1, 1, 8'd9, 1, 0, 1, 0, 2'd1, 0, 0, 16'h0, 1'b0, 5'd0));
        tbl.push_back(mk(1, 0, 8'd0, 0, 1, 0, 1, 2'd1, 0, 1, 16'h0007, 1'b0, 5'd3));
        // Mask D: single activation with in_last -> bit 0 only
        tbl.push_back(mk(1, 1, 8'd1, 1, 0, 1, 0, 2'd1, 0, 0, 16'h0, 1'b0, 5'd0));
        tbl.push_back(mk(1, 0, 8'd0, 0, 0, 0, 1, 2'd1, 0, 1, 16'h0001, 1'b1, 5'd1));
        // Drain both banks, then release once more while empty
        tbl.push_back(mk(1, 0, 8'd0, 0, 1, 0, 0, 2'd2, 0, 0, 16'h0, 1'b0, 5'd0));
        tbl.push_back(mk(1, 0, 8'd0, 0, 1, 1, 0, 2'd1, 0, 0, 16'h0, 1'b0, 5'd0));
        tbl.push_back(mk(1, 0, 8'd0, 0, 1, 1, 0, 2'd0, 0, 0, 16'h0, 1'b0, 5'd0));
        tbl.push_back(mk(1, 0, 8'd0, 0, 0, 1, 0, 2'd0, 1, 0, 16'h0, 1'b0, 5'd0));

        do_reset("init");
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("tbl[%0d]", i));

        // clk_en low mid-collection and during WRITE: mask 16'h801F at bank 0, written once
        for (int i = 0; i < 5; i++)
            apply(mk(1, 1, 8'd7, 0, 0, 1, 0, 2'd0, 1, 0, 16'h0, 1'b0, 5'd0), $sformatf("en_a%0d", i));
        for (int i = 0; i < 5; i++)
            apply(mk(0, 1, 8'd0, 0, 1, 0, 0, 2'd0, 1, 0, 16'h0, 1'b0, 5'd0), $sformatf("en_hold%0d", i));
        for (int i = 5; i < 16; i++)
            apply(mk(1, 1, (i == 15) ? 8'h80 : 8'd0, 0, 0, 1, 0, 2'd0, 1, 0, 16'h0, 1'b0, 5'd0),
                  $sformatf("en_b%0d", i));
        for (int i = 0; i < 5; i++)
            apply(mk(0, 0, 8'd0, 0, 0, 0, 0, 2'd0, 1, 0, 16'h0, 1'b0, 5'd0), $sformatf("en_wr_hold%0d", i));
        apply(mk(1, 0, 8'd0, 0, 0, 0, 1, 2'd0, 1, 1, 16'h801F, 1'b0, 5'd6), "en_write");
        apply(mk(1, 0, 8'd0, 0, 0, 1, 0, 2'd1, 1, 0, 16'h0, 1'b0, 5'd0), "en_after");

        // Reset after 7 accepts discards the partial mask and rewinds the write pointer
        for (int i = 0; i < 7; i++)
            apply(mk(1, 1, 8'h11, 0, 0, 1, 0, 2'd1, 1, 0, 16'h0, 1'b0, 5'd0), $sformatf("rs_pre%0d", i));
        do_reset("midrst");
        for (int i = 0; i < 16; i++)
            apply(mk(1, 1, (i < 8) ? 8'd0 : 8'h40, 0, 0, 1, 0, 2'd0, 0, 0, 16'h0, 1'b0, 5'd0),
                  $sformatf("rs_post%0d", i));
        apply(mk(1, 0, 8'd0, 0, 0, 0, 1, 2'd0, 0, 1, 16'hFF00, 1'b0, 5'd8), "rs_write");
        apply(mk(1, 0, 8'd0, 0, 0, 1, 0, 2'd1, 0, 0, 16'h0, 1'b0, 5'd0), "rs_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
